// File: rtl/sd_cmd_pkg.sv
// Shared SD command-path definitions: receiver FSM encodings, frame lengths, CRC7 polynomial.
package sd_cmd_pkg;

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      WAIT_START = 4'd1,
      RECEIVE    = 4'd2,
      DONE       = 4'd3
   } rx_state_t;

   localparam int FRAME_SHORT = 48;
   localparam int FRAME_LONG  = 136;

   // CRC window in a long frame skips the 8 header bits and the 8 trailer bits
   localparam int CRC_LONG_SKIP = FRAME_LONG - 128;
   localparam int CRC_TAIL      = 8;

   localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/cmd_response_receiver_if.sv
// Command-controller <-> response-receiver signal bundle.
interface cmd_response_receiver_if;
   logic         reset_wrapper;
   logic         enable_stp;
   logic         response_long;
   logic         cmd_pin_in;
   logic [135:0] pad_response;
   logic         reception_complete;
   logic         crc_error;

   modport master (
      output reset_wrapper, enable_stp, response_long, cmd_pin_in,
      input  pad_response, reception_complete, crc_error
   );

   modport slave (
      input  reset_wrapper, enable_stp, response_long, cmd_pin_in,
      output pad_response, reception_complete, crc_error
   );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), one bit per clock; clear has priority over enable.
module sd_crc7
   import sd_cmd_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic       i_bit,
   output logic [6:0] o_crc
);

   logic [6:0] r_crc;
   logic       w_fb;

   assign w_fb = i_bit ^ r_crc[6];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)   r_crc <= '0;
      else if (i_clr) r_crc <= '0;
      else if (i_en)  r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/cmd_response_receiver.sv
// SD CMD-line response receiver: detects the start bit, shifts in a 48/136-bit frame,
// checks CRC7 and end bit, and presents the frame until the controller drops enable.
module cmd_response_receiver
   import sd_cmd_pkg::*;
(
   input  logic                     sd_clock,
   input  logic                     reset,
   cmd_response_receiver_if.slave   bus
);

   localparam logic [7:0] LEN_S     = 8'(FRAME_SHORT);
   localparam logic [7:0] LEN_L     = 8'(FRAME_LONG);
   localparam logic [7:0] CRC_S_END = 8'(FRAME_SHORT - CRC_TAIL);
   localparam logic [7:0] CRC_L_BEG = 8'(CRC_LONG_SKIP);
   localparam logic [7:0] CRC_L_END = 8'(FRAME_LONG - CRC_TAIL);

   rx_state_t      r_state, w_state_nxt;
   logic [134:0]   r_shift;
   logic [7:0]     r_bit_cnt;
   logic           r_long;
   logic [135:0]   r_pad;
   logic           r_complete;
   logic           r_crc_err;

   logic [135:0]   w_shift_nxt;
   logic [7:0]     w_len;
   logic           w_last;
   logic           w_in_crc;
   logic           w_start;
   logic           w_crc_en;
   logic           w_crc_clr;
   logic           w_frame_err;
   logic [6:0]     w_crc;

   assign w_shift_nxt = {r_shift, bus.cmd_pin_in};
   assign w_len       = r_long ? LEN_L : LEN_S;
   // r_bit_cnt counts bits already taken, so the bit on the line now is r_bit_cnt+1
   assign w_last      = (r_bit_cnt == w_len - 8'd1);
   assign w_in_crc    = r_long ? (r_bit_cnt >= CRC_L_BEG && r_bit_cnt < CRC_L_END)
                               : (r_bit_cnt < CRC_S_END);
   assign w_start     = (r_state == WAIT_START) && bus.enable_stp && !bus.cmd_pin_in;

   // A short frame's start bit is already inside the CRC window; a long one's is not
   assign w_crc_en  = (w_start && !bus.response_long) ||
                      ((r_state == RECEIVE) && bus.enable_stp && w_in_crc);
   assign w_crc_clr = bus.reset_wrapper || (r_state == IDLE) || (r_state == DONE) ||
                      ((r_state == WAIT_START) && bus.cmd_pin_in);

   assign w_frame_err = (w_shift_nxt[7:1] != w_crc) || !w_shift_nxt[0];

   sd_crc7 u_crc (
      .i_clk   (sd_clock),
      .i_rst_n (reset),
      .i_clr   (w_crc_clr),
      .i_en    (w_crc_en),
      .i_bit   (bus.cmd_pin_in),
      .o_crc   (w_crc)
   );

   always_ff @(posedge sd_clock or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.reset_wrapper) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:       if (bus.enable_stp) w_state_nxt = WAIT_START;
            WAIT_START: if (!bus.enable_stp) w_state_nxt = IDLE;
                        else if (!bus.cmd_pin_in) w_state_nxt = RECEIVE;
            RECEIVE:    if (!bus.enable_stp) w_state_nxt = IDLE;
                        else if (w_last) w_state_nxt = DONE;
            DONE:       if (!bus.enable_stp) w_state_nxt = IDLE;
            default:    w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge sd_clock or negedge reset) begin
      if (!reset) begin
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_long     <= 1'b0;
         r_pad      <= '0;
         r_complete <= 1'b0;
         r_crc_err  <= 1'b0;
      end else if (bus.reset_wrapper) begin
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_long     <= 1'b0;
         r_pad      <= '0;
         r_complete <= 1'b0;
         r_crc_err  <= 1'b0;
      end else begin
         case (r_state)
            WAIT_START: if (w_start) begin
               r_shift   <= {134'b0, bus.cmd_pin_in};
               r_bit_cnt <= 8'd1;
               r_long    <= bus.response_long;
            end
            RECEIVE: if (bus.enable_stp) begin
               r_shift   <= w_shift_nxt[134:0];
               r_bit_cnt <= r_bit_cnt + 8'd1;
               if (w_last) begin
                  r_pad      <= r_long ? w_shift_nxt : {88'b0, w_shift_nxt[47:0]};
                  r_complete <= 1'b1;
                  r_crc_err  <= w_frame_err;
               end
            end
            DONE: if (!bus.enable_stp) begin
               r_complete <= 1'b0;
               r_crc_err  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.pad_response       = r_pad;
   assign bus.reception_complete = r_complete;
   assign bus.crc_error          = r_crc_err;

endmodule

// File: tb/tb_cmd_response_receiver.sv
// Directed bench for cmd_response_receiver: short/long frames, CRC and end-bit errors,
// aborts, idle line, async reset mid-frame and synchronous clear.
module tb_cmd_response_receiver;
   import sd_cmd_pkg::*;

   logic sd_clock = 1'b0;
   logic reset    = 1'b0;
   int   n_chk    = 0;
   int   n_pass   = 0;

   cmd_response_receiver_if bus ();

   cmd_response_receiver dut (
      .sd_clock (sd_clock),
      .reset    (reset),
      .bus      (bus)
   );

   always #5 sd_clock = ~sd_clock;

   task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Reference CRC7 over v[hi:lo], MSB first, initial value 0
   function automatic logic [6:0] crc7(input logic [135:0] v, input int hi, input int lo);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = hi; i >= lo; i--) begin
         fb = v[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   // Drop enable for a cycle, raise it, then drive n bits MSB first; returns one
   // cycle after the last bit was sampled.
   task automatic send_frame(input logic [135:0] v, input int n, input logic lng);
      @(negedge sd_clock); bus.enable_stp = 1'b0; bus.cmd_pin_in = 1'b1;
      @(negedge sd_clock); bus.enable_stp = 1'b1; bus.response_long = lng;
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge sd_clock);
         if (i == 0) check("complete_not_early", 136'(bus.reception_complete), 136'd0);
         bus.cmd_pin_in = v[i];
      end
      @(negedge sd_clock); bus.cmd_pin_in = 1'b1;
   endtask

   initial begin
      logic [135:0] lf;
      logic [135:0] lf_hdr;
      logic [135:0] lf_bad;
      logic [47:0]  sf;

      bus.reset_wrapper = 1'b0;
      bus.enable_stp    = 1'b0;
      bus.response_long = 1'b0;
      bus.cmd_pin_in    = 1'b1;
      repeat (3) @(negedge sd_clock);
      check("rst_pad",      bus.pad_response, 136'd0);
      check("rst_complete", 136'(bus.reception_complete), 136'd0);
      check("rst_crc_err",  136'(bus.crc_error), 136'd0);
      check("rst_state",    136'(dut.r_state), 136'(IDLE));
      reset = 1'b1;

      // Good short frame (CMD0-style, CRC 0x4A)
      send_frame(136'h400000000095, 48, 1'b0);
      check("s95_complete", 136'(bus.reception_complete), 136'd1);
      check("s95_pad",      bus.pad_response, 136'h400000000095);
      check("s95_crc_err",  136'(bus.crc_error), 136'd0);
      @(negedge sd_clock); bus.enable_stp = 1'b0;
      @(negedge sd_clock);
      check("s95_drop_state",    136'(dut.r_state), 136'(IDLE));
      check("s95_drop_complete", 136'(bus.reception_complete), 136'd0);
      check("s95_pad_held",      bus.pad_response, 136'h400000000095);

      // CRC field wrong
      send_frame(136'h400000000097, 48, 1'b0);
      check("s97_pad",     bus.pad_response, 136'h400000000097);
      check("s97_crc_err", 136'(bus.crc_error), 136'd1);

      // CRC right, end bit 0
      send_frame(136'h400000000094, 48, 1'b0);
      check("s94_complete", 136'(bus.reception_complete), 136'd1);
      check("s94_crc_err",  136'(bus.crc_error), 136'd1);

      // Abort mid-frame: pad keeps the last complete frame
      sf = 48'h400000000097;
      @(negedge sd_clock); bus.enable_stp = 1'b0;
      @(negedge sd_clock); bus.enable_stp = 1'b1;
      for (int i = 47; i >= 28; i--) begin
         @(negedge sd_clock); bus.cmd_pin_in = sf[i];
      end
      @(negedge sd_clock);
      check("abort_pad_mid", bus.pad_response, 136'h400000000094);
      bus.enable_stp = 1'b0; bus.cmd_pin_in = 1'b1;
      @(negedge sd_clock);
      check("abort_state",    136'(dut.r_state), 136'(IDLE));
      check("abort_complete", 136'(bus.reception_complete), 136'd0);
      check("abort_pad",      bus.pad_response, 136'h400000000094);

      // Long frame with valid CRC over [127:8]
      lf = {8'h3F, 120'h0123456789ABCDEFFEDCBA98765432, 8'h00};
      lf[7:1] = crc7(lf, 127, 8);
      lf[0]   = 1'b1;
      send_frame(lf, 136, 1'b1);
      check("long_complete", 136'(bus.reception_complete), 136'd1);
      check("long_pad",      bus.pad_response, lf);
      check("long_crc_err",  136'(bus.crc_error), 136'd0);
      check("long_bit_cnt",  136'(dut.r_bit_cnt), 136'd136);

      // Header bits [135:128] are outside the CRC
      lf_hdr = lf;
      lf_hdr[130] = ~lf_hdr[130];
      send_frame(lf_hdr, 136, 1'b1);
      check("long_hdr_pad",     bus.pad_response, lf_hdr);
      check("long_hdr_crc_err", 136'(bus.crc_error), 136'd0);

      // Bit 8 is inside the CRC
      lf_bad = lf;
      lf_bad[8] = ~lf_bad[8];
      send_frame(lf_bad, 136, 1'b1);
      check("long_bad_crc_err", 136'(bus.crc_error), 136'd1);

      // Synchronous clear wins over enable
      @(negedge sd_clock); bus.reset_wrapper = 1'b1;
      @(negedge sd_clock);
      check("rw_state",    136'(dut.r_state), 136'(IDLE));
      check("rw_complete", 136'(bus.reception_complete), 136'd0);
      check("rw_crc_err",  136'(bus.crc_error), 136'd0);
      check("rw_pad",      bus.pad_response, 136'd0);
      bus.reset_wrapper = 1'b0;

      // Idle line: stay in WAIT_START
      @(negedge sd_clock); bus.enable_stp = 1'b0; bus.cmd_pin_in = 1'b1;
      @(negedge sd_clock); bus.enable_stp = 1'b1;
      repeat (200) @(negedge sd_clock);
      check("idle_state",    136'(dut.r_state), 136'(WAIT_START));
      check("idle_complete", 136'(bus.reception_complete), 136'd0);
      bus.enable_stp = 1'b0;
      @(negedge sd_clock);
      check("idle_exit_state", 136'(dut.r_state), 136'(IDLE));

      // Async reset at bit 20 of a frame, after a good frame so outputs are non-zero
      send_frame(136'h400000000097, 48, 1'b0);
      sf = 48'h400000000095;
      @(negedge sd_clock); bus.enable_stp = 1'b0;
      @(negedge sd_clock); bus.enable_stp = 1'b1;
      for (int i = 47; i >= 28; i--) begin
         @(negedge sd_clock); bus.cmd_pin_in = sf[i];
      end
      @(posedge sd_clock); #2 reset = 1'b0;
      #1;
      check("arst_pad",      bus.pad_response, 136'd0);
      check("arst_complete", 136'(bus.reception_complete), 136'd0);
      check("arst_crc_err",  136'(bus.crc_error), 136'd0);
      check("arst_bit_cnt",  136'(dut.r_bit_cnt), 136'd0);
      check("arst_state",    136'(dut.r_state), 136'(IDLE));
      @(negedge sd_clock); bus.enable_stp = 1'b0; bus.cmd_pin_in = 1'b1; reset = 1'b1;
      send_frame(136'h400000000095, 48, 1'b0);
      check("post_rst_complete", 136'(bus.reception_complete), 136'd1);
      check("post_rst_pad",      bus.pad_response, 136'h400000000095);
      check("post_rst_crc_err",  136'(bus.crc_error), 136'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cmd_response_receiver.md
CMD_RESPONSE_RECEIVER -- requirements
Module: cmd_response_receiver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other inputs SHALL be sampled on the rising edge of sd_clock.
REQ-002 sd_clock  input  1  card-side clock; all sequential logic SHALL use its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 reset_wrapper  input  1  synchronous clear, active-high, from the command controller; it SHALL force IDLE and clear all outputs.
REQ-005 enable_stp  input  1  receive enable from the command controller; it SHALL be high for the whole response window.
REQ-006 response_long  input  1  frame length select: 1 = 136-bit (R2), 0 = 48-bit; it SHALL be sampled at start-bit detection only.
REQ-007 cmd_pin_in  input  1  serial CMD line, MSB first, idle high.
REQ-008 pad_response  output  136  received frame, right-justified; unused upper bits SHALL be 0.
REQ-009 reception_complete  output  1  frame fully captured; level signal.
REQ-010 crc_error  output  1  CRC7 mismatch or end bit 0; valid while reception_complete=1.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, WAIT_START, RECEIVE, DONE.
REQ-012 IDLE SHALL go to WAIT_START when enable_stp=1; otherwise it SHALL stay in IDLE.
REQ-013 WAIT_START SHALL go to RECEIVE on the edge where cmd_pin_in=0 is sampled; that start bit SHALL count as bit 1 and SHALL be shifted in.
REQ-014 RECEIVE SHALL shift cmd_pin_in into the LSB of the frame register every cycle and increment an 8-bit bit counter.
REQ-015 RECEIVE SHALL go to DONE after bit 48 (short frame) or bit 136 (long frame) has been sampled.
REQ-016 In DONE, reception_complete SHALL be 1 starting the cycle after the last bit is sampled, and SHALL hold until enable_stp=0; the FSM SHALL then return to IDLE.
REQ-017 pad_response SHALL be updated only on entry to DONE, and SHALL hold its value through IDLE until the next start bit.
REQ-018 Short-frame CRC7 (G(x)=x^7+x^3+1, initial value 0) SHALL cover frame bits [47:8] and SHALL be compared with bits [7:1].
REQ-019 Long-frame CRC7 SHALL cover bits [127:8] and SHALL be compared with bits [7:1]; bits [135:128] SHALL be excluded from the CRC.
REQ-020 crc_error SHALL be 1 when the CRC mismatches or bit[0] (end bit) is 0.
REQ-021 If enable_stp falls in WAIT_START or RECEIVE, the FSM SHALL abort to IDLE, discard the partial frame, and leave pad_response unchanged.
REQ-022 If reset_wrapper and enable_stp are both 1 in the same cycle, reset_wrapper SHALL win.
REQ-023 The block SHALL have no internal timeout; timeout is owned by the command controller.

Reset
REQ-024 When reset=0, the block SHALL asynchronously enter IDLE and clear pad_response, reception_complete, crc_error, the bit counter, and the CRC register to 0.
REQ-025 reset_wrapper=1 SHALL apply the same clear synchronously.
REQ-026 A reset asserted mid-frame SHALL discard the frame without asserting reception_complete.

Structure
REQ-027 A shared package sd_cmd_pkg SHALL hold the state encodings (4'd0..4'd3), FRAME_SHORT=48, FRAME_LONG=136, and CRC7_POLY=7'h09.
REQ-028 The CRC SHALL be a separate sub-module, sd_crc7 (serial, bit-per-clock, with enable and clear), shared with the command serializer.

Verification
REQ-029 enable_stp=1, response_long=0, serial 48'h400000000095 -> reception_complete=1 one cycle after bit 48, pad_response=136'h400000000095, crc_error=0.
REQ-030 Same stimulus with the last byte 8'h97 -> pad_response low bits 48'h400000000097, crc_error=1 (CRC mismatch).
REQ-031 Same stimulus with the last byte 8'h94 -> crc_error=1 (end bit 0).
REQ-032 response_long=1, 136-bit frame with correct CRC over [127:8] -> the full frame is captured, bit counter reaches 136, crc_error=0.
REQ-033 cmd_pin_in held at 1 for 200 cycles with enable_stp=1 -> FSM stays in WAIT_START, reception_complete=0; then enable_stp=0 -> IDLE.
REQ-034 Assert reset=0 at bit 20 of a frame -> all outputs are 0 immediately, and a subsequent 48'h400000000095 is received correctly.
